// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared widths, requester indices and FSM encoding for the panel frame scheduler
package panel_pkg;

    localparam int PANEL_X_W = 5;
    localparam int PANEL_Y_W = 4;
    localparam int COLOR_W   = 3;
    localparam int NUM_REQ   = 2;

    localparam logic REQ_R0 = 1'b0;
    localparam logic REQ_R1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GAP,
        ST_UPD_HI,
        ST_UPD_LO,
        ST_START
    } state_t;

endpackage

// File: rtl/panel_rr_arbiter.sv
// rtl/panel_rr_arbiter.sv - 2-way round-robin arbiter over masked requests with last-grant memory
module panel_rr_arbiter
    import panel_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic               grant,
    output logic [NUM_REQ-1:0] ready
);

    logic last_grant;

    always_comb begin
        grant = REQ_R0;
        if (req[REQ_R0] && req[REQ_R1]) begin
            grant = ~last_grant;
        end else if (req[REQ_R1]) begin
            grant = REQ_R1;
        end
        ready = '0;
        if (enable) begin
            ready[grant] = req[grant];
        end
    end

    // r1 is remembered as last winner so r0 takes the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_R1;
        end else if (|ready) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/panel_frame_scheduler.sv
// rtl/panel_frame_scheduler.sv - paces pixel writes and buffer swaps into ledpanel; PANEL_FRAME_TIMEOUT_EN adds forced swaps
module panel_frame_scheduler
    import panel_pkg::*;
#(
    parameter int CLK_FREQUENCY_HZ = 100000000,
    parameter int FRAME_RATE_HZ    = 60,
    parameter int CNTR_WIDTH       = 32,
    parameter int UPD_HOLD         = 2,
    parameter int TIMEOUT_CYCLES   = 3333333
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_enable,
    input  logic                 r0_valid,
    output logic                 r0_ready,
    input  logic [PANEL_X_W-1:0] r0_x,
    input  logic [PANEL_Y_W-1:0] r0_y,
    input  logic [COLOR_W-1:0]   r0_color,
    input  logic                 r0_frame_done,
    input  logic                 r1_valid,
    output logic                 r1_ready,
    input  logic [PANEL_X_W-1:0] r1_x,
    input  logic [PANEL_Y_W-1:0] r1_y,
    input  logic [COLOR_W-1:0]   r1_color,
    input  logic                 r1_frame_done,
    output logic [PANEL_X_W-1:0] x_address,
    output logic [PANEL_Y_W-1:0] y_address,
    output logic [COLOR_W-1:0]   color,
    output logic                 new_data,
    output logic                 update_panel,
    output logic                 frame_start,
    output logic                 busy,
`ifdef PANEL_FRAME_TIMEOUT_EN
    output logic                 timeout_flag,
`endif
    output logic [15:0]          frame_count
);

    localparam int MIN_FRAME = CLK_FREQUENCY_HZ / FRAME_RATE_HZ;
    localparam logic [CNTR_WIDTH-1:0] PERIOD_LAST = CNTR_WIDTH'(MIN_FRAME - 1);
    localparam int HOLD_W = $clog2(UPD_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(UPD_HOLD - 1);

    state_t                state;
    state_t                state_next;
    logic [CNTR_WIDTH-1:0] period_cnt;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [NUM_REQ-1:0]    done;
    logic [NUM_REQ-1:0]    pend;
    logic [NUM_REQ-1:0]    frame_done;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    ready;
    logic                  grant;
    logic                  accept;
    logic                  swap_due;
    logic                  force_swap;
    logic                  go_swap;
    logic                  in_swap;
    logic                  hold_end;

    assign frame_done = {r1_frame_done, r0_frame_done};
    assign swap_due   = ((done & req_enable) == req_enable)
                        && (period_cnt >= PERIOD_LAST)
                        && (req_enable != '0);
    assign go_swap    = swap_due || force_swap;
    assign req        = {r1_valid, r0_valid} & req_enable & ~done;
    assign accept     = |ready;
    assign r0_ready   = ready[REQ_R0];
    assign r1_ready   = ready[REQ_R1];
    assign in_swap    = (state == ST_UPD_HI) || (state == ST_UPD_LO) || (state == ST_START);
    assign hold_end   = (hold_cnt == HOLD_LAST);

    panel_rr_arbiter u_arbiter (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .enable ((state == ST_IDLE) && !go_swap),
        .grant  (grant),
        .ready  (ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        new_data     = 1'b0;
        update_panel = 1'b0;
        frame_start  = 1'b0;
        busy         = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (go_swap) begin
                    state_next = ST_UPD_HI;
                end else if (accept) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                new_data   = 1'b1;
                state_next = ST_GAP;
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            ST_UPD_HI: begin
                update_panel = 1'b1;
                if (hold_end) begin
                    state_next = ST_UPD_LO;
                end
            end
            ST_UPD_LO: begin
                if (hold_end) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                frame_start = 1'b1;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_address   <= '0;
            y_address   <= '0;
            color       <= '0;
            hold_cnt    <= '0;
            period_cnt  <= '0;
            frame_count <= '0;
        end else begin
            if (accept) begin
                x_address <= grant ? r1_x : r0_x;
                y_address <= grant ? r1_y : r0_y;
                color     <= grant ? r1_color : r0_color;
            end
            if ((state == ST_UPD_HI) || (state == ST_UPD_LO)) begin
                hold_cnt <= hold_end ? '0 : hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end
            if (state == ST_START) begin
                period_cnt  <= '0;
                frame_count <= frame_count + 16'd1;
            end else if (period_cnt < PERIOD_LAST) begin
                period_cnt <= period_cnt + CNTR_WIDTH'(1);
            end
        end
    end

    // frame_done seen while a swap is in flight belongs to the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= '0;
            pend <= '0;
        end else if (state == ST_START) begin
            done <= pend | frame_done;
            pend <= '0;
        end else if (in_swap) begin
            pend <= pend | frame_done;
        end else begin
            done <= done | frame_done;
        end
    end

`ifdef PANEL_FRAME_TIMEOUT_EN
    localparam logic [CNTR_WIDTH-1:0] TIMEOUT_LAST = CNTR_WIDTH'(TIMEOUT_CYCLES - 1);
    logic [CNTR_WIDTH-1:0] timeout_cnt;

    assign force_swap = (timeout_cnt == TIMEOUT_LAST) && (req_enable != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt  <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == ST_START) begin
                timeout_cnt <= '0;
            end else if (timeout_cnt != TIMEOUT_LAST) begin
                timeout_cnt <= timeout_cnt + CNTR_WIDTH'(1);
            end
            if ((state == ST_IDLE) && force_swap && !swap_due) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign force_swap         = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_panel_frame_scheduler.sv
// tb/tb_panel_frame_scheduler.sv - scoreboard bench for panel_frame_scheduler (MIN_FRAME=100, UPD_HOLD=2)
module tb_panel_frame_scheduler;

    typedef struct {
        logic [4:0] x;
        logic [3:0] y;
        logic [2:0] c;
    } wr_t;

    typedef struct {
        int cyc;
        int cnt;
    } fr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_enable = 2'b00;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic        r0_ready, r1_ready;
    logic [4:0]  r0_x = '0, r1_x = '0;
    logic [3:0]  r0_y = '0, r1_y = '0;
    logic [2:0]  r0_color = '0, r1_color = '0;
    logic        r0_frame_done = 1'b0, r1_frame_done = 1'b0;
    logic [4:0]  x_address;
    logic [3:0]  y_address;
    logic [2:0]  color;
    logic        new_data, update_panel, frame_start, busy;
    logic [15:0] frame_count;
`ifdef PANEL_FRAME_TIMEOUT_EN
    logic        timeout_flag;
`endif

    int  cyc;
    int  checks = 0;
    int  errors = 0;
    wr_t exp_wr[$];
    fr_t exp_fr[$];
    wr_t mon_w;
    fr_t mon_f;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    panel_frame_scheduler #(
        .CLK_FREQUENCY_HZ (6000),
        .FRAME_RATE_HZ    (60),
        .CNTR_WIDTH       (32),
        .UPD_HOLD         (2),
        .TIMEOUT_CYCLES   (500)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_enable    (req_enable),
        .r0_valid      (r0_valid),
        .r0_ready      (r0_ready),
        .r0_x          (r0_x),
        .r0_y          (r0_y),
        .r0_color      (r0_color),
        .r0_frame_done (r0_frame_done),
        .r1_valid      (r1_valid),
        .r1_ready      (r1_ready),
        .r1_x          (r1_x),
        .r1_y          (r1_y),
        .r1_color      (r1_color),
        .r1_frame_done (r1_frame_done),
        .x_address     (x_address),
        .y_address     (y_address),
        .color         (color),
        .new_data      (new_data),
        .update_panel  (update_panel),
        .frame_start   (frame_start),
        .busy          (busy),
`ifdef PANEL_FRAME_TIMEOUT_EN
        .timeout_flag  (timeout_flag),
`endif
        .frame_count   (frame_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0d required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic wr_t wd(input int k);
        wr_t w;
        w.x = 5'(3 * k + 1);
        w.y = 4'(k + 2);
        w.c = 3'(k + 1);
        return w;
    endfunction

    task automatic drive(input int r, input wr_t w);
        if (r == 0) begin
            r0_x = w.x; r0_y = w.y; r0_color = w.c;
        end else begin
            r1_x = w.x; r1_y = w.y; r1_color = w.c;
        end
    endtask

    // swap window whose UPD_HI starts at cycle hi
    task automatic chk_upd(input int hi);
        chk("update_panel", 32'(update_panel), 32'(cyc == hi || cyc == hi + 1));
        chk("frame_start", 32'(frame_start), 32'(cyc == hi + 4));
        chk("busy", 32'(busy), 32'(cyc >= hi && cyc <= hi + 4));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_enable = 2'b00;
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_frame_done = 1'b0; r1_frame_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("new_data_and_update", 32'(new_data & update_panel), 32'd0);
            if (new_data) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    mon_w = exp_wr.pop_front();
                    chk("write_x", 32'(x_address), 32'(mon_w.x));
                    chk("write_y", 32'(y_address), 32'(mon_w.y));
                    chk("write_color", 32'(color), 32'(mon_w.c));
                end
            end
            if (frame_start) begin
                if (exp_fr.size() == 0) begin
                    chk("unexpected_frame_start", 32'd1, 32'd0);
                end else begin
                    mon_f = exp_fr.pop_front();
                    chk("frame_start_cycle", 32'(cyc), 32'(mon_f.cyc));
                    chk("frame_count_at_start", 32'(frame_count), 32'(mon_f.cnt));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: actual running required finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ups;
        wr_t w;

        // reset state
        @(negedge clk);
        chk("rst_update_panel", 32'(update_panel), 32'd0);
        chk("rst_new_data", 32'(new_data), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_x", 32'(x_address), 32'd0);
        chk("rst_y", 32'(y_address), 32'd0);
        chk("rst_color", 32'(color), 32'd0);
        chk("rst_r0_ready", 32'(r0_ready), 32'd0);
        chk("rst_r1_ready", 32'(r1_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_enable = 2'b11;

        // both valid: r0 wins the first tie, then strict alternation every 3 cycles
        goto(2);
        drive(0, wd(0));
        drive(1, wd(1));
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            goto(2 + 3 * k);
            #1;
            chk("alt_r0_ready", 32'(r0_ready), 32'(k % 2 == 0));
            chk("alt_r1_ready", 32'(r1_ready), 32'(k % 2 == 1));
            exp_wr.push_back(wd(k));
            goto(3 + 3 * k);
            chk("alt_write_ready", 32'({r0_ready, r1_ready}), 32'd0);
            chk("alt_write_strobe", 32'(new_data), 32'd1);
            if (k + 2 < 6) drive(k % 2, wd(k + 2));
            else if (k % 2 == 0) r0_valid = 1'b0;
            else r1_valid = 1'b0;
            goto(4 + 3 * k);
            chk("alt_gap_ready", 32'({r0_ready, r1_ready}), 32'd0);
            chk("alt_gap_strobe", 32'(new_data), 32'd0);
        end

        // r0 alone: one-cycle strobe, address/colour held through WRITE and GAP
        goto(20);
        w.x = 5'd3; w.y = 4'd5; w.c = 3'b110;
        drive(0, w);
        r0_valid = 1'b1;
        #1;
        chk("single_ready", 32'(r0_ready), 32'd1);
        exp_wr.push_back(w);
        goto(21);
        chk("single_write_strobe", 32'(new_data), 32'd1);
        chk("single_write_ready", 32'(r0_ready), 32'd0);
        chk("single_write_x", 32'(x_address), 32'd3);
        chk("single_write_y", 32'(y_address), 32'd5);
        chk("single_write_color", 32'(color), 32'd6);
        w.x = 5'd7; w.y = 4'd2; w.c = 3'd1;
        drive(0, w);
        goto(22);
        chk("single_gap_strobe", 32'(new_data), 32'd0);
        chk("single_gap_ready", 32'(r0_ready), 32'd0);
        chk("single_gap_x", 32'(x_address), 32'd3);
        chk("single_gap_y", 32'(y_address), 32'd5);
        chk("single_gap_color", 32'(color), 32'd6);
        goto(23);
        chk("single_rearm_ready", 32'(r0_ready), 32'd1);
        exp_wr.push_back(w);
        goto(24);
        r0_valid = 1'b0;

        // frame timing: done at 10 and 20, swap at MIN_FRAME
        do_reset();
        req_enable = 2'b11;
        exp_fr.push_back('{104, 0});
        exp_fr.push_back('{209, 1});
        exp_fr.push_back('{314, 2});
        exp_fr.push_back('{419, 3});
        goto(10); r0_frame_done = 1'b1;
        goto(11); r0_frame_done = 1'b0;
        goto(12);
        r0_valid = 1'b1;
        #1;
        chk("done_blocks_ready", 32'(r0_ready), 32'd0);
        goto(13); r0_valid = 1'b0;
        goto(20); r1_frame_done = 1'b1;
        goto(21); r1_frame_done = 1'b0;
        for (int c = 95; c <= 106; c++) begin
            goto(c);
            chk_upd(100);
            if (c == 105) chk("frame_count_after_1", 32'(frame_count), 32'd1);
        end

        // r0_frame_done during UPD_HI carries into the following frame
        goto(150); r0_frame_done = 1'b1;
        goto(151); r0_frame_done = 1'b0;
        goto(160); r1_frame_done = 1'b1;
        goto(161); r1_frame_done = 1'b0;
        for (int c = 200; c <= 209; c++) begin
            goto(c);
            chk_upd(205);
            r0_frame_done = (c == 205);
        end
        goto(210);
        w.x = 5'd17; w.y = 4'd9; w.c = 3'd5;
        drive(0, w);
        r0_valid = 1'b1;
        for (int c = 210; c <= 315; c++) begin
            goto(c);
            #1;
            chk("pending_done_ready", 32'(r0_ready), 32'(c == 315));
            chk_upd(310);
            r1_frame_done = (c == 250);
        end
        exp_wr.push_back(w);
        goto(316);
        r0_valid = 1'b0;

        // r1 disabled: never ready, swap follows r0 alone
        goto(320);
        req_enable = 2'b01;
        drive(1, wd(3));
        r1_valid = 1'b1;
        for (int c = 320; c <= 425; c++) begin
            goto(c);
            #1;
            chk("disabled_r1_ready", 32'(r1_ready), 32'd0);
            chk_upd(415);
            r0_frame_done = (c == 330);
        end

        // reset in the middle of UPD_HI
        goto(430); r0_frame_done = 1'b1;
        goto(431); r0_frame_done = 1'b0;
        goto(520);
        chk("upd_before_reset", 32'(update_panel), 32'd1);
        #2;
        rst_n = 1'b0;
        r1_valid = 1'b0;
        req_enable = 2'b00;
        #1;
        chk("upd_in_reset", 32'(update_panel), 32'd0);
        chk("count_in_reset", 32'(frame_count), 32'd0);
        chk("busy_in_reset", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        goto(3);
        chk("idle_after_reset", 32'(busy), 32'd0);
        chk("count_after_reset", 32'(frame_count), 32'd0);
        chk("upd_after_reset", 32'(update_panel), 32'd0);

`ifdef PANEL_FRAME_TIMEOUT_EN
        // r1 never done: forced swap 500 cycles into the frame
        req_enable = 2'b11;
        exp_fr.push_back('{504, 0});
        goto(5); r0_frame_done = 1'b1;
        goto(6); r0_frame_done = 1'b0;
        goto(499);
        chk("timeout_flag_before", 32'(timeout_flag), 32'd0);
        for (int c = 500; c <= 505; c++) begin
            goto(c);
            chk_upd(500);
        end
        chk("timeout_flag_after", 32'(timeout_flag), 32'd1);
        do_reset();
`endif

        // no requester enabled: no swap even with done pulses and a full period
        req_enable = 2'b00;
        ups = 0;
        for (int c = 1; c <= 250; c++) begin
            goto(c);
            if (update_panel) ups++;
            r0_frame_done = (c == 5);
            r1_frame_done = (c == 5);
        end
        chk("no_swap_when_disabled", 32'(ups), 32'd0);

        chk("write_queue_drained", 32'(exp_wr.size()), 32'd0);
        chk("frame_queue_drained", 32'(exp_fr.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
